// File: rtl/ps2_defs.sv
// rtl/ps2_defs.sv - PS/2 shared constants, tx state encoding and parity helper
package ps2_defs;

  localparam logic [7:0] PS2_BREAK    = 8'hF0;
  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_LSHIFT   = 8'h12;
  localparam logic [7:0] PS2_RSHIFT   = 8'h59;
  localparam logic [7:0] PS2_CAPS     = 8'h58;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_RTS,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_ACK,
    TX_WAIT_REL
  } tx_state_t;

  // Parity bit that makes the 9-bit word {parity, data} carry an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - 8-sample debounce of the PS/2 clock with falling-edge tick
module ps2_clk_filter (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  output logic level,
  output logic fall_tick
);

  logic [7:0] samples;
  logic       level_next;

  always_comb begin
    level_next = level;
    if (samples == 8'hFF)
      level_next = 1'b1;
    else if (samples == 8'h00)
      level_next = 1'b0;
  end

  assign fall_tick = level & ~level_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      samples <= 8'hFF;
      level   <= 1'b1;
    end else begin
      samples <= {ps2c_in, samples[7:1]};
      level   <= level_next;
    end
  end

endmodule

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command transmitter with ACK check and timeout
module ps2_tx
  import ps2_defs::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_drv,
  output logic       ps2d_drv,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  tx_state_t     state, state_next;
  logic [8:0]    shift, shift_next;
  logic [3:0]    nbit, nbit_next;
  logic [IW-1:0] icnt, icnt_next;
  logic [TW-1:0] tcnt, tcnt_next;
  logic          ack_ok, ack_ok_next;
  logic          done_next, err_next;
  logic          clk_level, fall_tick;
  logic          timed_out;

  ps2_clk_filter u_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2c_in   (ps2c_in),
    .level     (clk_level),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= TX_IDLE;
      shift        <= '0;
      nbit         <= '0;
      icnt         <= '0;
      tcnt         <= '0;
      ack_ok       <= 1'b0;
      tx_done_tick <= 1'b0;
      tx_err_tick  <= 1'b0;
    end else begin
      state        <= state_next;
      shift        <= shift_next;
      nbit         <= nbit_next;
      icnt         <= icnt_next;
      tcnt         <= tcnt_next;
      ack_ok       <= ack_ok_next;
      tx_done_tick <= done_next;
      tx_err_tick  <= err_next;
    end
  end

  // Timeout only guards the phases where the device owns the clock.
  assign timed_out = (tcnt == TW'(TIMEOUT_CYCLES)) &&
                     (state != TX_IDLE) && (state != TX_RTS);

  always_comb begin
    state_next  = state;
    shift_next  = shift;
    nbit_next   = nbit;
    icnt_next   = icnt;
    tcnt_next   = tcnt;
    ack_ok_next = ack_ok;
    done_next   = 1'b0;
    err_next    = 1'b0;
    if (timed_out) begin
      state_next = TX_IDLE;
      err_next   = 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          if (wr_ps2) begin
            shift_next = {odd_parity(din), din};
            nbit_next  = '0;
            icnt_next  = '0;
            tcnt_next  = '0;
            state_next = TX_RTS;
          end
        end
        TX_RTS: begin
          if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
            tcnt_next  = '0;
            state_next = TX_START;
          end else begin
            icnt_next = icnt + 1'b1;
          end
        end
        TX_START: begin
          if (fall_tick) begin
            tcnt_next  = '0;
            state_next = TX_DATA;
          end else begin
            tcnt_next = tcnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (fall_tick) begin
            tcnt_next  = '0;
            shift_next = {1'b1, shift[8:1]};
            nbit_next  = nbit + 1'b1;
            if (nbit == 4'd8)
              state_next = TX_STOP;
          end else begin
            tcnt_next = tcnt + 1'b1;
          end
        end
        TX_STOP: begin
          // Device pulls data low across the final falling edge to acknowledge.
          if (fall_tick) begin
            tcnt_next   = '0;
            ack_ok_next = ~ps2d_in;
            state_next  = TX_ACK;
          end else begin
            tcnt_next = tcnt + 1'b1;
          end
        end
        TX_ACK: begin
          state_next = TX_WAIT_REL;
        end
        TX_WAIT_REL: begin
          if (clk_level && ps2d_in) begin
            done_next  = ack_ok;
            err_next   = ~ack_ok;
            state_next = TX_IDLE;
          end else begin
            tcnt_next = tcnt + 1'b1;
          end
        end
        default: state_next = TX_IDLE;
      endcase
    end
  end

  always_comb begin
    ps2c_drv = 1'b0;
    ps2d_drv = 1'b0;
    case (state)
      TX_RTS: begin
        ps2c_drv = 1'b1;
        ps2d_drv = 1'b1;
      end
      TX_START: ps2d_drv = 1'b1;
      TX_DATA:  ps2d_drv = ~shift[0];
      default: begin
        ps2c_drv = 1'b0;
        ps2d_drv = 1'b0;
      end
    endcase
  end

  assign tx_idle = (state == TX_IDLE);

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - randomized device-BFM bench for ps2_tx
module tb_ps2_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       bfm_c = 1'b1;
  logic       bfm_d = 1'b1;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_drv, ps2d_drv, tx_idle, tx_done_tick, tx_err_tick;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  // Open-drain wiring: either side pulling low wins.
  assign ps2c_in = bfm_c & ~ps2c_drv;
  assign ps2d_in = bfm_d & ~ps2d_drv;

  ps2_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(300)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c_in      (ps2c_in),
    .ps2d_in      (ps2d_in),
    .ps2c_drv     (ps2c_drv),
    .ps2d_drv     (ps2d_drv),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .tx_err_tick  (tx_err_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) done_cnt++;
    if (tx_err_tick === 1'b1) err_cnt++;
    if (tx_done_tick === 1'b1 && tx_err_tick === 1'b1) both_cnt++;
  end

  // Expected line sequence: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bfm_edge(input logic glitch, output logic seen);
    bfm_c = 1'b0;
    cyc(20);
    seen = ps2d_in;
    bfm_c = 1'b1;
    if (glitch) begin
      cyc(10);
      bfm_c = 1'b0;
      cyc(2);
      bfm_c = 1'b1;
      cyc(8);
    end else begin
      cyc(20);
    end
  endtask

  task automatic start_req(input logic [7:0] d, output int rts_n);
    din = d;
    wr_ps2 = 1'b1;
    cyc(1);
    wr_ps2 = 1'b0;
    rts_n = 0;
    while (ps2c_drv === 1'b1 && ps2d_drv === 1'b1 && rts_n < 1000) begin
      rts_n++;
      cyc(1);
    end
    cyc(20);
  endtask

  task automatic do_transfer(input logic [7:0] d, input logic ack, input logic glitch,
                             input logic mid_wr, output logic [10:0] frame, output int rts_n);
    int n;
    logic b;
    frame = '0;
    start_req(d, rts_n);
    frame[0] = ps2d_in;
    for (int i = 1; i <= 10; i++) begin
      bfm_edge(glitch, b);
      frame[i] = b;
      if (mid_wr && i == 3) begin
        din = 8'hFF;
        wr_ps2 = 1'b1;
        cyc(1);
        wr_ps2 = 1'b0;
      end
    end
    bfm_d = ~ack;
    bfm_c = 1'b0;
    cyc(20);
    bfm_c = 1'b1;
    cyc(5);
    bfm_d = 1'b1;
    n = 0;
    while (tx_idle !== 1'b1 && n < 500) begin
      n++;
      cyc(1);
    end
    cyc(3);
  endtask

  task automatic check_xfer(input string name, input logic [7:0] d, input logic ack,
                            input logic glitch, input logic mid_wr);
    logic [10:0] frame, exp;
    int rts_n, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    exp = model_frame(d);
    do_transfer(d, ack, glitch, mid_wr, frame, rts_n);
    total_cnt++;
    if (rts_n !== 20) $display("FAIL %s rts_cycles got %0d want 20", name, rts_n);
    else pass_cnt++;
    total_cnt++;
    if (frame !== exp) $display("FAIL %s frame got %03h want %03h", name, frame, exp);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt - d0 !== (ack ? 1 : 0))
      $display("FAIL %s done_ticks got %0d want %0d", name, done_cnt - d0, ack ? 1 : 0);
    else pass_cnt++;
    total_cnt++;
    if (err_cnt - e0 !== (ack ? 0 : 1))
      $display("FAIL %s err_ticks got %0d want %0d", name, err_cnt - e0, ack ? 0 : 1);
    else pass_cnt++;
    total_cnt++;
    if (tx_idle !== 1'b1) $display("FAIL %s tx_idle got %b want 1", name, tx_idle);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    total_cnt++;
    if (ps2c_drv !== 1'b0) $display("FAIL reset ps2c_drv got %b want 0", ps2c_drv);
    else pass_cnt++;
    total_cnt++;
    if (ps2d_drv !== 1'b0) $display("FAIL reset ps2d_drv got %b want 0", ps2d_drv);
    else pass_cnt++;
    total_cnt++;
    if (tx_idle !== 1'b1) $display("FAIL reset tx_idle got %b want 1", tx_idle);
    else pass_cnt++;
    total_cnt++;
    if ({tx_done_tick, tx_err_tick} !== 2'b00)
      $display("FAIL reset ticks got %b want 00", {tx_done_tick, tx_err_tick});
    else pass_cnt++;
    cyc(5);
  endtask

  task automatic test_set_leds;
    check_xfer("set_leds_ED", 8'hED, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_parity;
    check_xfer("parity_00_ack", 8'h00, 1'b1, 1'b0, 1'b0);
    check_xfer("parity_07_nack", 8'h07, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic [7:0] d;
    logic ack;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      check_xfer($sformatf("random_%0d", i), d, ack, 1'b0, 1'b0);
    end
  endtask

  task automatic test_glitch;
    check_xfer("glitch", 8'($urandom), 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    int extra;
    check_xfer("ignored_wr", 8'h3C, 1'b1, 1'b0, 1'b1);
    extra = 0;
    for (int i = 0; i < 50; i++) begin
      if (ps2c_drv === 1'b1) extra++;
      cyc(1);
    end
    total_cnt++;
    if (extra !== 0) $display("FAIL queued_request ps2c_drv_cycles got %0d want 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    int rts_n, n, d0, e0;
    logic b;
    d0 = done_cnt;
    e0 = err_cnt;
    start_req(8'hA5, rts_n);
    for (int i = 0; i < 3; i++) bfm_edge(1'b0, b);
    bfm_c = 1'b0;
    n = 0;
    while (tx_err_tick !== 1'b1 && n < 1000) begin
      cyc(1);
      n++;
      if (n == 20) bfm_c = 1'b1;
    end
    total_cnt++;
    if (n < 300 || n > 330) $display("FAIL timeout latency got %0d want 300..330", n);
    else pass_cnt++;
    total_cnt++;
    if ({ps2c_drv, ps2d_drv} !== 2'b00)
      $display("FAIL timeout drv got %b want 00", {ps2c_drv, ps2d_drv});
    else pass_cnt++;
    total_cnt++;
    if (tx_idle !== 1'b1) $display("FAIL timeout tx_idle got %b want 1", tx_idle);
    else pass_cnt++;
    cyc(3);
    total_cnt++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0)
      $display("FAIL timeout ticks got err %0d done %0d want err 1 done 0",
               err_cnt - e0, done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int rts_n, d0, e0;
    logic b;
    start_req(8'h5A, rts_n);
    for (int i = 0; i < 5; i++) bfm_edge(1'b0, b);
    bfm_c = 1'b0;
    cyc(12);
    d0 = done_cnt;
    e0 = err_cnt;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    total_cnt++;
    if ({ps2c_drv, ps2d_drv} !== 2'b00)
      $display("FAIL reset_mid drv got %b want 00", {ps2c_drv, ps2d_drv});
    else pass_cnt++;
    bfm_c = 1'b1;
    cyc(60);
    total_cnt++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0)
      $display("FAIL reset_mid ticks got done %0d err %0d want 0 0",
               done_cnt - d0, err_cnt - e0);
    else pass_cnt++;
    total_cnt++;
    if (tx_idle !== 1'b1) $display("FAIL reset_mid tx_idle got %b want 1", tx_idle);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_set_leds;
    test_parity;
    test_random;
    test_glitch;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    total_cnt++;
    if (both_cnt !== 0) $display("FAIL tick_exclusive overlap got %0d want 0", both_cnt);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
